// File: rtl/disp_rd_scheduler_if.sv
// rtl/disp_rd_scheduler_if.sv - burst read request channel between the display read scheduler and the memory controller
interface disp_rd_scheduler_if #(
  parameter int ADDR_W = 28
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_ack;
  logic              rd_done;

  modport master (
    output rd_req, rd_addr, rd_len,
    input  rd_ack, rd_done
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
    output rd_ack, rd_done
  );
endinterface

// File: rtl/disp_rd_scheduler.sv
// rtl/disp_rd_scheduler.sv - sequences DDR burst reads into the display read FIFO, restarting at every frame sync
// Optional ping-pong bank selection is enabled by defining DISP_RD_PINGPONG_EN.
module disp_rd_scheduler #(
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] FRAME_BASE0 = 28'h000_0000,
  parameter logic [ADDR_W-1:0] FRAME_BASE1 = 28'h010_0000,
  parameter int                FRAME_WORDS = 384000,
  parameter int                BURST_LEN   = 64,
  parameter int                FIFO_DEPTH  = 1024,
  parameter int                LVL_W       = 11,
  parameter int                FLUSH_CYC   = 4,
  parameter logic              VSYNC_POL   = 1'b1
) (
  input  logic               pixel_clock,
  input  logic               reset,
  input  logic               rd_load,
  input  logic               wr_frame_done,
  input  logic               wr_bank,
  input  logic [LVL_W-1:0]   fifo_level,
  output logic               fifo_clr,
  output logic               cur_bank,
  output logic               busy,
  output logic               frame_late,
  disp_rd_scheduler_if.master rd_bus
);

  localparam logic [15:0]     LVL_THRESH = 16'(FIFO_DEPTH - BURST_LEN);
  localparam int              FC_W       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);
  localparam logic [23:0]     FRAME_REM  = 24'(FRAME_WORDS);
  localparam logic [7:0]      BURST_MAX  = 8'(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    WAIT_LVL,
    REQ,
    XFER,
    DONE
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              rd_load_d;
  logic              sync_edge;
  logic [FC_W-1:0]   flush_cnt;
  logic [23:0]       remaining;
  logic              pending;
  logic              latest_bank;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [7:0]        burst_len;
  logic [15:0]       lvl_ext;
  logic              active;
  logic              burst_end;

  assign sync_edge = (rd_load == VSYNC_POL) && (rd_load_d != VSYNC_POL);
  assign lvl_ext   = 16'(fifo_level);
  assign burst_len = (remaining < 24'(BURST_LEN)) ? remaining[7:0] : BURST_MAX;
  assign active    = (state == FLUSH) || (state == WAIT_LVL) || (state == REQ) || (state == XFER);
  assign burst_end = (state == XFER) && rd_bus.rd_done;

  assign fifo_clr       = (state == FLUSH);
  assign busy           = active;
  assign rd_bus.rd_req  = (state == REQ);
  assign rd_bus.rd_addr = rd_addr_q;
  assign rd_bus.rd_len  = burst_len;

`ifdef DISP_RD_PINGPONG_EN
  // Only the writer's most recent completion is remembered; it is consumed at FLUSH entry.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      latest_bank <= 1'b0;
    end else if (wr_frame_done) begin
      latest_bank <= wr_bank;
    end
  end
`else
  logic unused_pingpong;
  assign latest_bank     = 1'b0;
  assign unused_pingpong = wr_frame_done ^ wr_bank;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (sync_edge) next_state = FLUSH;
      end
      FLUSH: begin
        if (!sync_edge && flush_cnt == FLUSH_LAST) next_state = WAIT_LVL;
      end
      WAIT_LVL: begin
        if (sync_edge) begin
          next_state = FLUSH;
        end else if (remaining == 24'd0) begin
          next_state = DONE;
        end else if (lvl_ext <= LVL_THRESH) begin
          next_state = REQ;
        end
      end
      REQ: begin
        if (rd_bus.rd_ack) next_state = XFER;
      end
      XFER: begin
        if (rd_bus.rd_done) next_state = (pending || sync_edge) ? FLUSH : WAIT_LVL;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_load_d  <= ~VSYNC_POL;
      flush_cnt  <= '0;
      remaining  <= 24'd0;
      pending    <= 1'b0;
      rd_addr_q  <= FRAME_BASE0;
      cur_bank   <= 1'b0;
      frame_late <= 1'b0;
    end else begin
      state      <= next_state;
      rd_load_d  <= rd_load;
      frame_late <= sync_edge && active;
      // A sync during FLUSH restarts the flush window from its first cycle.
      flush_cnt  <= (state == FLUSH && !sync_edge) ? flush_cnt + 1'b1 : '0;

      if (state == FLUSH && flush_cnt == '0) begin
        cur_bank  <= latest_bank;
        rd_addr_q <= latest_bank ? FRAME_BASE1 : FRAME_BASE0;
        remaining <= FRAME_REM;
      end

      if (burst_end) begin
        rd_addr_q <= rd_addr_q + ADDR_W'(burst_len);
        remaining <= remaining - 24'(burst_len);
      end

      // A sync while a burst is outstanding is deferred until that burst lands.
      if (burst_end) begin
        pending <= 1'b0;
      end else if ((state == REQ || state == XFER) && sync_edge) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
